// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: bus widths, FSM state encoding
// and the quotient returned for a zero divisor.
package div_iter_pkg;

    localparam int RegBus       = 32;
    localparam int DivResultBus = 64;

    localparam logic [RegBus-1:0] DivZeroQuot = 32'hFFFF_FFFF;
    localparam logic [4:0]        LastIter    = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the
// {rem,quot} pair left, trial-subtract the divisor, keep or restore.
module div_step
    import div_iter_pkg::*;
(
    input  logic [RegBus-1:0] rem,
    input  logic [RegBus-1:0] quot,
    input  logic [RegBus-1:0] divisor,
    output logic [RegBus-1:0] rem_next,
    output logic [RegBus-1:0] quot_next
);

    logic [RegBus:0] shifted;
    logic [RegBus:0] diff;

    // The shifted partial remainder needs 33 bits; diff[RegBus] is the borrow/sign.
    always_comb begin
        shifted = {rem, quot[RegBus-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[RegBus]) begin
            rem_next  = diff[RegBus-1:0];
            quot_next = {quot[RegBus-2:0], 1'b1};
        end else begin
            rem_next  = shifted[RegBus-1:0];
            quot_next = {quot[RegBus-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter.sv
// 32-cycle iterative DIV/DIVU unit with an IDLE/BUSY/DONE handshake to the EX stage.
// Define DIV_ZERO_FAST_EN to let a zero divisor bypass BUSY and finish in one cycle.
module div_iter
    import div_iter_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    signed_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    annul_i,
    output logic [DivResultBus-1:0] result_o,
    output logic                    ready_o,
    output logic                    stallreq_o
);

`ifdef DIV_ZERO_FAST_EN
    localparam bit FastZero = 1'b1;
`else
    localparam bit FastZero = 1'b0;
`endif

    div_state_t state, next_state;

    logic [4:0]              cnt;
    logic [RegBus-1:0]       dividend;
    logic [RegBus-1:0]       divisor;
    logic                    sign_mode;
    logic [RegBus-1:0]       divisor_mag;
    logic [RegBus-1:0]       rem;
    logic [RegBus-1:0]       quot;
    logic [RegBus-1:0]       step_rem;
    logic [RegBus-1:0]       step_quot;
    logic [DivResultBus-1:0] result_q;

    logic              accept;
    logic              divisor_zero_in;
    logic [RegBus-1:0] op1_mag;
    logic [RegBus-1:0] op2_mag;
    logic              quot_neg;
    logic              rem_neg;
    logic [RegBus-1:0] final_quot;
    logic [RegBus-1:0] final_rem;

    assign accept          = (state == IDLE) && start_i && !annul_i;
    assign divisor_zero_in = (opdata2_i == '0);

    // Magnitudes are taken at acceptance; 0x80000000 stays 0x80000000 as unsigned.
    assign op1_mag = (signed_i && opdata1_i[RegBus-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_mag = (signed_i && opdata2_i[RegBus-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    assign quot_neg   = sign_mode && (dividend[RegBus-1] ^ divisor[RegBus-1]);
    assign rem_neg    = sign_mode && dividend[RegBus-1];
    assign final_quot = quot_neg ? (~step_quot + 1'b1) : step_quot;
    assign final_rem  = rem_neg  ? (~step_rem + 1'b1)  : step_rem;

    div_step u_step (
        .rem       (rem),
        .quot      (quot),
        .divisor   (divisor_mag),
        .rem_next  (step_rem),
        .quot_next (step_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Annul wins over everything; dropping start mid-BUSY also abandons the divide.
    always_comb begin
        next_state = state;
        if (annul_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        next_state = (FastZero && divisor_zero_in) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (!start_i) begin
                        next_state = IDLE;
                    end else if (cnt == LastIter) begin
                        next_state = DONE;
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o    = (state == DONE);
        stallreq_o = start_i && (state != DONE) && !annul_i;
        result_o   = result_q;
    end

    // The result register is written only on entry to DONE so it holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            dividend    <= '0;
            divisor     <= '0;
            sign_mode   <= 1'b0;
            divisor_mag <= '0;
            rem         <= '0;
            quot        <= '0;
            result_q    <= '0;
        end else if (accept) begin
            dividend    <= opdata1_i;
            divisor     <= opdata2_i;
            sign_mode   <= signed_i;
            divisor_mag <= op2_mag;
            rem         <= '0;
            quot        <= op1_mag;
            cnt         <= '0;
            if (next_state == DONE) begin
                result_q <= {opdata1_i, DivZeroQuot};
            end
        end else if ((state == BUSY) && (next_state != IDLE)) begin
            rem  <= step_rem;
            quot <= step_quot;
            cnt  <= cnt + 5'd1;
            if (next_state == DONE) begin
                if (divisor == '0) begin
                    result_q <= {dividend, DivZeroQuot};
                end else begin
                    result_q <= {final_rem, final_quot};
                end
            end
        end
    end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: rising-edge clock.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have the port start_i, input, 1 bit: a divide instruction occupies EX; held high by EX until result accepted.
REQ-004 The block SHALL have the port signed_i, input, 1 bit: 1 = DIV (two's complement), 0 = DIVU.
REQ-005 The block SHALL have the port opdata1_i, input, 32 bits: dividend; sampled only on acceptance.
REQ-006 The block SHALL have the port opdata2_i, input, 32 bits: divisor; sampled only on acceptance.
REQ-007 The block SHALL have the port annul_i, input, 1 bit: abort the operation in flight.
REQ-008 The block SHALL have the port result_o, output, 64 bits: {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 The block SHALL have the port ready_o, output, 1 bit: result_o valid this cycle.
REQ-010 The block SHALL have the port stallreq_o, output, 1 bit: feeds the EX stall request to the pipeline controller, which stalls IF/ID/EX.

Function
REQ-011 The block SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-012 In IDLE, start_i=1 and annul_i=0 SHALL latch the operands and signed_i, and SHALL go to BUSY with the iteration counter set to 0.
REQ-013 In BUSY, each cycle SHALL perform one restoring step on magnitudes: shift {rem,quot} left by 1, subtract |divisor| from the upper part, keep the result if non-negative and set quotient bit 1, otherwise restore.
REQ-014 BUSY SHALL last exactly 32 cycles (counter 0..31); on the 32nd cycle the sign fix-up SHALL be applied and the state SHALL go to DONE.
REQ-015 DONE SHALL last exactly one cycle with ready_o=1 and result_o valid, then SHALL go unconditionally to IDLE.
REQ-016 Latency SHALL be: start seen in IDLE at cycle 0, BUSY during cycles 1..32, DONE at cycle 33.
REQ-017 stallreq_o SHALL equal start_i & ~ready_o & ~annul_i, so it is high in cycles 0..32 and low in DONE.
REQ-018 A back-to-back divide SHALL be accepted in the IDLE cycle immediately after DONE, with no lost cycle beyond that IDLE.
REQ-019 Signed operation SHALL negate the quotient when the operand signs differ and SHALL give the remainder the sign of the dividend.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0.
REQ-021 A divisor of 0 SHALL yield quotient 0xFFFFFFFF and remainder opdata1_i unmodified, for both DIV and DIVU.
REQ-022 annul_i=1 in any state SHALL force IDLE on the next edge with ready_o=0 and no result delivered; annul takes priority over start.
REQ-023 start_i dropping to 0 during BUSY SHALL abort the operation to IDLE on the next edge.
REQ-024 result_o SHALL hold its last DONE value while in IDLE and BUSY; it is meaningful only when ready_o=1.

Reset
REQ-025 rst SHALL force state IDLE, counter 0, result_o=0, ready_o=0 and the internal operand registers to 0.
REQ-026 rst SHALL override annul_i and start_i.
REQ-027 rst asserted mid-BUSY SHALL discard the operation, and the first cycle after reset SHALL be IDLE.

Configuration
REQ-028 With DIV_ZERO_FAST_EN defined, a divisor of 0 seen at acceptance SHALL skip BUSY and go straight to DONE at cycle 1 with the REQ-021 result, and stallreq_o SHALL be high at cycle 0 only.
REQ-029 With DIV_ZERO_FAST_EN undefined, a divisor of 0 SHALL take the full 33-cycle path, and the REQ-021 result SHALL be forced at entry to DONE.

Structure
REQ-030 The shared defines header SHALL hold the state encodings, DivResultBus (64), RegBus (32) and the divide-by-zero quotient constant.
REQ-031 One combinational sub-module, div_step, SHALL implement a single restoring iteration and SHALL be instanced once.
REQ-032 Magnitude conversion and sign fix-up SHALL be written inline in div_iter.

Verification
REQ-033 The bench SHALL check DIVU 100/7 with start held -> stallreq_o high for 33 cycles, ready_o at cycle 33, result_o={32'd2,32'd14}.
REQ-034 The bench SHALL check DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; and 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-035 The bench SHALL check DIV 0x80000000/0xFFFFFFFF -> {0, 0x80000000}; and DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
REQ-036 The bench SHALL check divisor 0 with dividend 0x1234 -> {0x1234, 0xFFFFFFFF}, ready_o at cycle 1 with DIV_ZERO_FAST_EN defined and at cycle 33 without it.
REQ-037 The bench SHALL check annul_i pulsed at cycle 10 -> IDLE at cycle 11, ready_o never asserted; a new start is then accepted and completes correctly.
REQ-038 The bench SHALL check two back-to-back divides (start held across DONE) -> second accepted at cycle 34, its ready_o at cycle 67, and check rst at cycle 5 -> all outputs 0 at the next cycle.
